// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: two-master Avalon-style bus arbiter (m0 = instruction fetch, m1 = load/store)
//   FAIR        : 1 = round-robin on ties, 0 = m0 wins ties
//   clk, reset  : single clock, synchronous active-high reset
//   m0_*, m1_*  : requester ports (address/read/write/writedata/byteenable in, waitrequest/readdata out)
//   address, read, write, writedata, byteenable, waitrequest, readdata : shared bus side
//   grant       : one-hot current owner (bit0 = m0), 00 when idle
//   proto_err   : sticky, set when the owner drives read and write together
module mem_bus_arbiter #(
  parameter bit FAIR = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] m0_address,
  input  logic        m0_read,
  input  logic        m0_write,
  input  logic [31:0] m0_writedata,
  input  logic [3:0]  m0_byteenable,
  output logic        m0_waitrequest,
  output logic [31:0] m0_readdata,
  input  logic [31:0] m1_address,
  input  logic        m1_read,
  input  logic        m1_write,
  input  logic [31:0] m1_writedata,
  input  logic [3:0]  m1_byteenable,
  output logic        m1_waitrequest,
  output logic [31:0] m1_readdata,
  output logic [31:0] address,
  output logic        read,
  output logic        write,
  output logic [31:0] writedata,
  output logic [3:0]  byteenable,
  input  logic        waitrequest,
  input  logic [31:0] readdata,
  output logic [1:0]  grant,
  output logic        proto_err
);
  localparam logic [1:0] IDLE = 2'b00;
  localparam logic [1:0] OWN0 = 2'b01;
  localparam logic [1:0] OWN1 = 2'b10;
  logic [1:0] state, state_n;
  logic       last, last_n;
  logic       req0, req1, own0, own1, done;
  function automatic logic [1:0] pick(input logic r0, input logic r1, input logic lst);
    return (r0 & r1) ? ((FAIR && !lst) ? OWN1 : OWN0) : r0 ? OWN0 : r1 ? OWN1 : IDLE;
  endfunction
  assign req0 = m0_read | m0_write;
  assign req1 = m1_read | m1_write;
  assign own0 = state == OWN0;
  assign own1 = state == OWN1;
  assign done = ((own0 & req0) | (own1 & req1)) & ~waitrequest;
  // On completion the finished master is excluded, so a pending peer gets a zero-bubble handover
  // while the same master re-requesting goes through one IDLE arbitration cycle.
  always_comb begin
    state_n = own0 ? (!req0 ? IDLE : !waitrequest ? pick(1'b0, req1, last) : OWN0) :
              own1 ? (!req1 ? IDLE : !waitrequest ? pick(req0, 1'b0, last) : OWN1) :
              pick(req0, req1, last);
    last_n  = done ? own1 : last;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      last      <= 1'b1;
      proto_err <= 1'b0;
    end else begin
      state     <= state_n;
      last      <= last_n;
      proto_err <= proto_err | (own0 & m0_read & m0_write) | (own1 & m1_read & m1_write);
    end
  end
  // Bus mirrors the owner; a read+write collision is resolved in favour of write.
  assign address        = own0 ? m0_address : own1 ? m1_address : '0;
  assign writedata      = own0 ? m0_writedata : own1 ? m1_writedata : '0;
  assign byteenable     = own0 ? m0_byteenable : own1 ? m1_byteenable : '0;
  assign write          = (own0 & m0_write) | (own1 & m1_write);
  assign read           = (own0 & m0_read & ~m0_write) | (own1 & m1_read & ~m1_write);
  assign m0_waitrequest = own0 ? waitrequest : 1'b1;
  assign m1_waitrequest = own1 ? waitrequest : 1'b1;
  assign m0_readdata    = readdata;
  assign m1_readdata    = readdata;
  assign grant          = {own1, own0};
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter: scoreboard bench for mem_bus_arbiter (FAIR=1 main DUT, FAIR=0 companion for tie checks)
module tb_mem_bus_arbiter;
  logic        clk, reset;
  logic [31:0] m0_address, m1_address, m0_writedata, m1_writedata;
  logic        m0_read, m1_read, m0_write, m1_write;
  logic [3:0]  m0_byteenable, m1_byteenable;
  logic        waitrequest;
  logic [31:0] readdata;
  logic        m0_waitrequest, m1_waitrequest, read, write, proto_err;
  logic [31:0] m0_readdata, m1_readdata, address, writedata;
  logic [3:0]  byteenable;
  logic [1:0]  grant;
  logic        g1_m0_waitrequest, g1_m1_waitrequest, g1_read, g1_write, g1_proto_err;
  logic [31:0] g1_m0_readdata, g1_m1_readdata, g1_address, g1_writedata;
  logic [3:0]  g1_byteenable;
  logic [1:0]  g1_grant;
  int          n_pass = 0, n_total = 0;
  typedef struct {
    logic [1:0]  g;
    logic [31:0] a;
    logic        w;
    logic [31:0] wd;
    logic [3:0]  be;
    logic [31:0] rd;
  } exp_t;
  exp_t q[$];
  mem_bus_arbiter #(.FAIR(1'b1)) u0 (
    .clk(clk), .reset(reset),
    .m0_address(m0_address), .m0_read(m0_read), .m0_write(m0_write), .m0_writedata(m0_writedata),
    .m0_byteenable(m0_byteenable), .m0_waitrequest(m0_waitrequest), .m0_readdata(m0_readdata),
    .m1_address(m1_address), .m1_read(m1_read), .m1_write(m1_write), .m1_writedata(m1_writedata),
    .m1_byteenable(m1_byteenable), .m1_waitrequest(m1_waitrequest), .m1_readdata(m1_readdata),
    .address(address), .read(read), .write(write), .writedata(writedata), .byteenable(byteenable),
    .waitrequest(waitrequest), .readdata(readdata), .grant(grant), .proto_err(proto_err)
  );
  mem_bus_arbiter #(.FAIR(1'b0)) u1 (
    .clk(clk), .reset(reset),
    .m0_address(m0_address), .m0_read(m0_read), .m0_write(m0_write), .m0_writedata(m0_writedata),
    .m0_byteenable(m0_byteenable), .m0_waitrequest(g1_m0_waitrequest), .m0_readdata(g1_m0_readdata),
    .m1_address(m1_address), .m1_read(m1_read), .m1_write(m1_write), .m1_writedata(m1_writedata),
    .m1_byteenable(m1_byteenable), .m1_waitrequest(g1_m1_waitrequest), .m1_readdata(g1_m1_readdata),
    .address(g1_address), .read(g1_read), .write(g1_write), .writedata(g1_writedata),
    .byteenable(g1_byteenable), .waitrequest(waitrequest), .readdata(readdata), .grant(g1_grant),
    .proto_err(g1_proto_err)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, got, exp);
  endtask
  task automatic push(input logic [1:0] g, input logic [31:0] a, input logic w,
                      input logic [31:0] wd, input logic [3:0] be, input logic [31:0] rd);
    exp_t e;
    e.g = g; e.a = a; e.w = w; e.wd = wd; e.be = be; e.rd = rd;
    q.push_back(e);
  endtask
  task automatic nxt;
    @(posedge clk);
    #1;
  endtask
  task automatic clr;
    m0_address = '0; m0_read = 0; m0_write = 0; m0_writedata = '0; m0_byteenable = '0;
    m1_address = '0; m1_read = 0; m1_write = 0; m1_writedata = '0; m1_byteenable = '0;
  endtask
  task automatic do_reset;
    reset = 1; clr; waitrequest = 0; readdata = '0;
    nxt; nxt;
    reset = 0;
  endtask
  // Monitor: every bus completion seen on the FAIR=1 DUT is matched against the next expected transfer.
  always @(negedge clk) begin
    if (!reset && (read || write) && !waitrequest) begin
      if (q.size() == 0) begin
        chk("unexpected_completion", {grant, address}, '0);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("completion",
            {grant, address, read, write, writedata, byteenable, m0_waitrequest, m1_waitrequest,
             grant[1] ? m1_readdata : m0_readdata},
            {e.g, e.a, ~e.w, e.w, e.wd, e.be, e.g != 2'b01, e.g != 2'b10, e.rd});
      end
    end
  end
  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal;
  end
  initial begin
    logic [1:0] alt [3];
    alt = '{2'b01, 2'b10, 2'b01};
    // reset with live requests present: outputs must still be idle
    reset = 1; clr; waitrequest = 0; readdata = 32'hFFFF0000;
    m0_read = 1; m0_address = 32'h1234; m1_write = 1; m1_address = 32'h5678; m1_byteenable = 4'hF;
    nxt; nxt;
    @(negedge clk);
    chk("reset_idle",
        {grant, read, write, address, writedata, byteenable, m0_waitrequest, m1_waitrequest, proto_err, g1_grant},
        {2'b00, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 1'b1, 1'b0, 2'b00});
    nxt;
    clr; reset = 0;
    nxt;
    // single read, then m0 re-requests alone (one idle bubble), then a tie with last=m0
    m0_read = 1; m0_address = 32'hBFC00000; m0_byteenable = 4'hF; waitrequest = 0; readdata = 32'h2402000A;
    push(2'b01, 32'hBFC00000, 1'b0, 32'h0, 4'hF, 32'h2402000A);
    @(negedge clk);
    chk("t1_request_cycle", {m0_waitrequest, read, grant}, {1'b1, 1'b0, 2'b00});
    nxt;
    @(negedge clk);
    chk("t1_bus_cycle", {read, address}, {1'b1, 32'hBFC00000});
    nxt;
    @(negedge clk);
    chk("t1_idle_after", {grant, read}, {2'b00, 1'b0});
    nxt;
    push(2'b01, 32'hBFC00000, 1'b0, 32'h0, 4'hF, 32'h2402000A);
    nxt;
    m1_read = 1; m1_address = 32'h200; m1_byteenable = 4'hF;
    nxt;
    push(2'b10, 32'h200, 1'b0, 32'h0, 4'hF, 32'h2402000A);
    @(negedge clk);
    chk("fair_tie_after_m0", grant, 2'b10);
    chk("prio_tie_after_m0", g1_grant, 2'b01);
    nxt;
    clr;
    @(negedge clk);
    chk("handover_then_abandon", {grant, read, write}, {2'b01, 1'b0, 1'b0});
    do_reset;
    // m1 write with three slave wait states
    m1_write = 1; m1_address = 32'h1000; m1_writedata = 32'hDEADBEEF; m1_byteenable = 4'b0011;
    waitrequest = 1; readdata = 32'hCAFEF00D;
    @(negedge clk);
    chk("t2_request_cycle", {m1_waitrequest, grant}, {1'b1, 2'b00});
    for (int i = 0; i < 3; i++) begin
      nxt;
      @(negedge clk);
      chk("t2_wait_state",
          {grant, write, read, address, writedata, byteenable, m1_waitrequest, m0_waitrequest},
          {2'b10, 1'b1, 1'b0, 32'h1000, 32'hDEADBEEF, 4'b0011, 1'b1, 1'b1});
    end
    nxt;
    waitrequest = 0;
    push(2'b10, 32'h1000, 1'b1, 32'hDEADBEEF, 4'b0011, 32'hCAFEF00D);
    nxt;
    clr;
    @(negedge clk);
    chk("t2_idle_after", grant, 2'b00);
    do_reset;
    // continuous simultaneous requests from reset: zero-bubble alternation starting with m0
    m0_read = 1; m0_address = 32'h100; m0_byteenable = 4'hF;
    m1_read = 1; m1_address = 32'h200; m1_byteenable = 4'hF;
    readdata = 32'h0BADC0DE;
    push(2'b01, 32'h100, 1'b0, 32'h0, 4'hF, 32'h0BADC0DE);
    push(2'b10, 32'h200, 1'b0, 32'h0, 4'hF, 32'h0BADC0DE);
    push(2'b01, 32'h100, 1'b0, 32'h0, 4'hF, 32'h0BADC0DE);
    @(negedge clk);
    chk("t3_arb_cycle", grant, 2'b00);
    for (int i = 0; i < 3; i++) begin
      nxt;
      @(negedge clk);
      chk("t3_alternate", grant, alt[i]);
    end
    nxt;
    clr;
    do_reset;
    // reset while m1 owns the bus and the slave waits
    m1_read = 1; m1_address = 32'h300; m1_byteenable = 4'hF; waitrequest = 1;
    nxt;
    @(negedge clk);
    chk("t4_owned", grant, 2'b10);
    nxt;
    reset = 1;
    nxt;
    reset = 0; m0_read = 1; m0_address = 32'h100; m0_byteenable = 4'hF; waitrequest = 0; readdata = 32'h11112222;
    push(2'b01, 32'h100, 1'b0, 32'h0, 4'hF, 32'h11112222);
    push(2'b10, 32'h300, 1'b0, 32'h0, 4'hF, 32'h11112222);
    @(negedge clk);
    chk("t4_after_reset", {read, write, grant}, {1'b0, 1'b0, 2'b00});
    nxt;
    @(negedge clk);
    chk("t4_tie_to_m0", grant, 2'b01);
    nxt;
    nxt;
    clr;
    do_reset;
    // protocol error: m1 drives read and write together
    m1_read = 1; m1_write = 1; m1_address = 32'h400; m1_writedata = 32'h12345678; m1_byteenable = 4'hF;
    waitrequest = 1; readdata = 32'h00000009;
    nxt;
    @(negedge clk);
    chk("t5_strobes", {write, read, proto_err}, {1'b1, 1'b0, 1'b0});
    nxt;
    waitrequest = 0;
    push(2'b10, 32'h400, 1'b1, 32'h12345678, 4'hF, 32'h00000009);
    @(negedge clk);
    chk("t5_err_set", proto_err, 1'b1);
    nxt;
    clr;
    @(negedge clk);
    chk("t5_err_held", proto_err, 1'b1);
    nxt; nxt;
    @(negedge clk);
    chk("t5_err_sticky", proto_err, 1'b1);
    do_reset;
    @(negedge clk);
    chk("t5_reset_clears", proto_err, 1'b0);
    nxt;
    // abandon: m0 drops its read while waiting; last must stay at its reset value
    m0_read = 1; m0_address = 32'h500; m0_byteenable = 4'hF; waitrequest = 1;
    nxt;
    @(negedge clk);
    chk("t6_owned", grant, 2'b01);
    nxt;
    m0_read = 0;
    @(negedge clk);
    chk("t6_dropped", {grant, read, write}, {2'b01, 1'b0, 1'b0});
    nxt;
    m0_read = 1; m1_read = 1; m1_address = 32'h600; m1_byteenable = 4'hF;
    @(negedge clk);
    chk("t6_idle", {grant, read, write}, {2'b00, 1'b0, 1'b0});
    nxt;
    @(negedge clk);
    chk("t6_last_kept", grant, 2'b01);
    do_reset;
    nxt;
    chk("scoreboard_drained", q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/mem_bus_arbiter.md
# mem_bus_arbiter

Two-master arbiter that shares the CPU's single Avalon-style memory port between an instruction-fetch requester (m0) and a load/store requester (m1). It sits between the two requester ports and the external bus: `address`, `read`, `write`, `writedata`, `byteenable`, `waitrequest` and `readdata`. It serialises transactions, holds a grant across slave wait states, and returns per-master `waitrequest`/`readdata`. Arbitration is round-robin with a fixed-priority option.

## Interface
- `FAIR`, default 1: 1 = round-robin on simultaneous requests; 0 = m0 always wins ties.
- `clk` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: synchronous, active-high.
- `m0_address`, `m1_address` in 32: requester addresses.
- `m0_read`, `m1_read`, `m0_write`, `m1_write` in 1: requester strobes, held while own waitrequest is high.
- `m0_writedata`, `m1_writedata` in 32: write data.
- `m0_byteenable`, `m1_byteenable` in 4: byte lanes.
- `m0_waitrequest`, `m1_waitrequest` out 1: stall to each requester.
- `m0_readdata`, `m1_readdata` out 32: read return.
- `address` out 32, `read` out 1, `write` out 1, `writedata` out 32, `byteenable` out 4: bus side.
- `waitrequest` in 1, `readdata` in 32: bus side.
- `grant` out 2: one-hot current owner (bit0 = m0); 00 when idle.
- `proto_err` out 1: sticky flag, set when a granted master asserts `read` and `write` together.

## Operation
- States: IDLE, OWN0, OWN1. `last` register records the last master served.
- IDLE:
  - No requests: stay in IDLE.
  - Exactly one requester (read|write): go to OWNx.
  - Both requesting: with FAIR=1, go to the master other than `last`; with FAIR=0, go to OWN0.
- OWNx:
  - Bus outputs mirror master x combinationally.
  - `mx_waitrequest` = `waitrequest`.
  - The non-owner's waitrequest is held at 1.
- Completion: a cycle in OWNx with (`mx_read`|`mx_write`) and `waitrequest`=0.
  - On that edge, `last`<=x.
  - Next state is chosen by the IDLE rules from the requests present in that cycle, excluding x. This gives a zero-bubble handover to a pending other master; otherwise the next state is IDLE.
- Abandon: in OWNx, if master x has both strobes low, go to IDLE and leave `last` unchanged.
- Read+write both high from the owner:
  - Drive `write`=1 and `read`=0.
  - Set `proto_err`; it clears only on reset.
- `m0_readdata` = `m1_readdata` = `readdata` (broadcast). Data is valid only to the owner, in its completion cycle.
- Outputs in IDLE: `read`=`write`=0; `address`, `writedata` and `byteenable` are 0; both `mx_waitrequest` are 1; `grant`=00.
- Reset (any state, including mid-transaction):
  - Next cycle: IDLE, `last`=1 (so m0 wins the first tie), `proto_err`=0, all outputs at their IDLE values.
  - The abandoned bus transaction is not reissued.

## Timing
- Arbitration latency is 1 cycle. A request first seen in cycle N is issued on the bus in cycle N+1. `mx_waitrequest`=1 in cycle N.
- Minimum transaction is 2 cycles (request cycle plus one bus cycle with `waitrequest`=0). Each slave wait cycle adds 1.
- Back-to-back from two masters: master 2's bus cycle immediately follows master 1's completion cycle; no idle cycle.
- The same master requesting again right after its own completion, with no competitor, needs 1 IDLE arbitration cycle.
- The grant never changes while `waitrequest`=1 for the owner.
- `grant` and the state are registered; bus outputs are combinational from the registered state and the owner's inputs.

## Test plan
- Single read: `m0_read`=1, `m0_address`=0xBFC00000, slave `waitrequest`=0 and `readdata`=0x2402000A. Required: `read`=1 with `address`=0xBFC00000 in cycle 1; `m0_waitrequest` low in cycle 1 with `m0_readdata`=0x2402000A; IDLE in cycle 2.
- Wait states: m1 write to 0x1000, `writedata`=0xDEADBEEF, `byteenable`=0011, slave `waitrequest`=1 for 3 cycles. Required: bus signals stable for 4 cycles; `m1_waitrequest` tracks the slave; one completion.
- Simultaneous requests from reset with FAIR=1: both request continuously. Required: grants alternate m0, m1, m0 with no idle cycles between. With FAIR=0: m0 is granted every arbitration.
- Reset mid-transaction: assert `reset` during OWN1 while the slave waits. Required: next cycle `read`=`write`=0, `grant`=00; first subsequent tie goes to m0.
- Protocol error: owner m1 asserts read and write together. Required: `write`=1, `read`=0, `proto_err`=1, and it stays 1 until reset.
- Abandon: m0 granted, then drops `m0_read` before completion. Required: IDLE next cycle, `last` unchanged, no bus strobe in that cycle.
